// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one shared ALU, one req/ready memory port used for both
// instruction fetch and data access, and an internal 32x32 register file.
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [31:0] pc_o,
  output logic        retire_o,
  output logic        halt_o,
  output logic        illegal_o
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  state_e      state, state_next;
  logic [31:0] pc, pc_instr, ir, reg_a, reg_b, target, alu_out, mdr;
  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic        legal, retire;

  logic [31:0] alu_a, alu_b, alu_y;
  logic [5:0]  alu_fn;

  logic [31:0] rf_a, rf_b, rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_we;

  logic        unused_shamt;

  assign opcode       = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign imm_sext     = {{16{ir[15]}}, ir[15:0]};
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpRtype:                        legal = funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
      OpAddi, OpLw, OpSw, OpBeq, OpJ: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
  end

  // The single ALU computes pc+4 in FETCH, the branch target in DECODE and the
  // arithmetic result or effective address in EXEC.
  always_comb begin
    alu_a  = pc;
    alu_b  = 32'd4;
    alu_fn = FnAdd;
    case (state)
      StDecode: alu_b = {imm_sext[29:0], 2'b00};
      StExec: begin
        alu_a = reg_a;
        if (opcode == OpRtype) begin
          alu_b  = reg_b;
          alu_fn = funct;
        end else begin
          alu_b = imm_sext;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_fn)
      FnSub:   alu_y = alu_a - alu_b;
      FnAnd:   alu_y = alu_a & alu_b;
      FnOr:    alu_y = alu_a | alu_b;
      FnSlt:   alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  assign rf_a     = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rf_b     = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign rf_waddr = (opcode == OpRtype) ? rd : rt;
  assign rf_wdata = (opcode == OpLw) ? mdr : alu_out;
  assign rf_we    = (state == StWb) && (rf_waddr != 5'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= StFetch;
      pc       <= RESET_PC;
      pc_instr <= RESET_PC;
      ir       <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      target   <= '0;
      alu_out  <= '0;
      mdr      <= '0;
    end else begin
      state <= state_next;
      case (state)
        StFetch: begin
          if (mem_ready_i) begin
            ir       <= mem_rdata_i;
            pc_instr <= pc;
            pc       <= alu_y;
          end
        end
        StDecode: begin
          reg_a  <= rf_a;
          reg_b  <= rf_b;
          target <= alu_y;
          if (legal && opcode == OpJ) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        StExec: begin
          alu_out <= alu_y;
          if (opcode == OpBeq && reg_a == reg_b) pc <= target;
        end
        StMem: begin
          if (mem_ready_i) mdr <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      StFetch: begin
        if (mem_ready_i) state_next = StDecode;
      end
      StDecode: begin
        if (!legal) begin
          if (HALT_ON_ILLEGAL) begin
            state_next = StHalt;
          end else begin
            retire     = 1'b1;
            state_next = StFetch;
          end
        end else if (opcode == OpJ) begin
          retire     = 1'b1;
          state_next = StFetch;
        end else begin
          state_next = StExec;
        end
      end
      StExec: begin
        case (opcode)
          OpLw, OpSw: state_next = StMem;
          OpBeq: begin
            retire     = 1'b1;
            state_next = StFetch;
          end
          default: state_next = StWb;
        endcase
      end
      StMem: begin
        if (mem_ready_i) begin
          if (opcode == OpSw) begin
            retire     = 1'b1;
            state_next = StFetch;
          end else begin
            state_next = StWb;
          end
        end
      end
      StWb: begin
        retire     = 1'b1;
        state_next = StFetch;
      end
      StHalt:  state_next = StHalt;
      default: state_next = StFetch;
    endcase
  end

  // Reset state is FETCH, so the request and address are gated by reset to stay quiet.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    if (rst_i) begin
      case (state)
        StFetch: begin
          mem_req_o  = 1'b1;
          mem_addr_o = {pc[31:2], 2'b00};
        end
        StMem: begin
          mem_req_o  = 1'b1;
          mem_addr_o = {alu_out[31:2], 2'b00};
          if (opcode == OpSw) begin
            mem_we_o    = 1'b1;
            mem_wdata_o = reg_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_o      = pc_instr;
  assign retire_o  = retire;
  assign halt_o    = (state == StHalt);
  assign illegal_o = (state == StHalt);

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: table-driven programs with a retire/write scoreboard, plus
// directed sequences for reset, illegal-as-NOP and reset during a pending load.
module tb_multi_cycle_cpu;

  localparam logic [31:0] ResetPc = 32'h0000_0100;

  typedef struct { logic [31:0] addr; logic [31:0] instr; int unsigned cyc; } vec_t;
  typedef struct { logic [31:0] pc; int unsigned cyc; } ret_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  logic        clk = 1'b0;
  logic        rst_n, mem_req, mem_we, mem_ready, retire, halt, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        rst2, req2, we2, retire2, halt2, illegal2;
  logic [31:0] addr2, wdata2, rdata2, pc2;

  logic [31:0] mem [256];
  vec_t        prog [$];
  ret_t        ret_q [$];
  wr_t         wr_q [$];
  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned wait_ins, wait_dat, wcnt;
  logic [31:0] halt_pc;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign rdata2    = (addr2 == 32'd0) ? 32'hFC00_0000 : 32'h0022_183F;

  multi_cycle_cpu #(.RESET_PC(ResetPc), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_n), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .pc_o(pc), .retire_o(retire), .halt_o(halt),
    .illegal_o(illegal)
  );

  multi_cycle_cpu #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk_i(clk), .rst_i(rst2), .mem_req_o(req2), .mem_we_o(we2),
    .mem_addr_o(addr2), .mem_wdata_o(wdata2), .mem_rdata_i(rdata2),
    .mem_ready_i(1'b1), .pc_o(pc2), .retire_o(retire2), .halt_o(halt2),
    .illegal_o(illegal2)
  );

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] instr, input int unsigned cyc);
    vec_t v;
    v.addr = a; v.instr = instr; v.cyc = cyc;
    prog.push_back(v);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  // Memory responder: decides ready at each negedge, data region is below 0x100.
  task automatic drive_mem();
    int unsigned lim;
    if (mem_req) begin
      lim       = (mem_addr < 32'h100) ? wait_dat : wait_ins;
      mem_ready = (wcnt >= lim);
      wcnt      = mem_ready ? 0 : wcnt + 1;
    end else begin
      mem_ready = 1'b1;
      wcnt      = 0;
    end
  endtask

  task automatic run_prog(input int unsigned wi, input int unsigned wd, input bit chk_reset);
    ret_t        r;
    wr_t         w;
    int unsigned cyc;
    bit          halted;
    wait_ins = wi; wait_dat = wd; wcnt = 0;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    foreach (prog[k]) begin
      mem[prog[k].addr[9:2]] = prog[k].instr;
      if (prog[k].cyc != 0) begin
        r.pc = prog[k].addr; r.cyc = prog[k].cyc;
        ret_q.push_back(r);
      end else begin
        halt_pc = prog[k].addr;
      end
    end
    repeat (2) @(posedge clk);
    if (chk_reset) begin
      #1;
      check("reset req", {31'd0, mem_req}, 32'd0);
      check("reset we", {31'd0, mem_we}, 32'd0);
      check("reset addr", mem_addr, 32'd0);
      check("reset wdata", mem_wdata, 32'd0);
      check("reset retire", {31'd0, retire}, 32'd0);
      check("reset halt", {31'd0, halt}, 32'd0);
      check("reset illegal", {31'd0, illegal}, 32'd0);
      check("reset pc_o", pc, ResetPc);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    if (chk_reset) begin
      #1;
      check("first req", {31'd0, mem_req}, 32'd1);
      check("first addr", mem_addr, ResetPc);
    end
    cyc = 0;
    halted = 1'b0;
    for (int t = 0; t < 500 && !halted; t++) begin
      @(negedge clk);
      drive_mem();
      #1;
      cyc++;
      if (retire) begin
        if (ret_q.size() == 0) begin
          fail("retire", $sformatf("unexpected retire at pc %h", pc));
        end else begin
          r = ret_q.pop_front();
          check("retire pc", pc, r.pc);
          check("retire cycles", cyc, r.cyc);
        end
        cyc = 0;
      end
      if (mem_req && mem_we && mem_ready) begin
        if (wr_q.size() == 0) begin
          fail("write", $sformatf("unexpected write to %h", mem_addr));
        end else begin
          w = wr_q.pop_front();
          check("write addr", mem_addr, w.addr);
          check("write data", mem_wdata, w.data);
        end
        mem[mem_addr[9:2]] = mem_wdata;
      end
      if (halt) begin
        halted = 1'b1;
        check("halt illegal", {31'd0, illegal}, 32'd1);
        check("halt pc_o", pc, halt_pc);
      end
    end
    if (!halted) fail("halt", "core did not halt within 500 cycles");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("req after halt", {31'd0, mem_req}, 32'd0);
      check("halt held", {31'd0, halt}, 32'd1);
    end
    check("retires pending", ret_q.size(), 32'd0);
    check("writes pending", wr_q.size(), 32'd0);
    prog.delete();
    ret_q.delete();
    wr_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit reached;
    rst_n = 1'b0;
    rst2 = 1'b0;
    mem_ready = 1'b1;
    wcnt = 0;

    // Illegal instructions retire as NOPs in 2 cycles when halting is disabled.
    @(posedge clk);
    #1 rst2 = 1'b1;
    @(negedge clk); #1;
    check("nop req", {31'd0, req2}, 32'd1);
    check("nop addr0", addr2, 32'h0);
    @(negedge clk); #1;
    check("nop retire0", {31'd0, retire2}, 32'd1);
    check("nop pc0", pc2, 32'h0);
    check("nop halt", {31'd0, halt2}, 32'd0);
    @(negedge clk); #1;
    check("nop addr4", addr2, 32'h4);
    check("nop we", {31'd0, we2}, 32'd0);
    check("nop wdata", wdata2, 32'd0);
    @(negedge clk); #1;
    check("nop retire4", {31'd0, retire2}, 32'd1);
    check("nop pc4", pc2, 32'h4);
    check("nop illegal", {31'd0, illegal2}, 32'd0);
    @(negedge clk); #1;
    check("nop addr8", addr2, 32'h8);

    // ALU ops, $0 handling and wraparound; results observed through stores.
    add(32'h100, enc_i(6'h08, 0, 1, 16'd5), 4);
    add(32'h104, enc_i(6'h08, 0, 2, 16'hFFFD), 4);
    add(32'h108, enc_r(1, 2, 3, 6'h20), 4);
    add(32'h10C, enc_r(2, 1, 4, 6'h2A), 4);
    add(32'h110, enc_i(6'h2B, 0, 3, 16'h20), 4);
    add(32'h114, enc_i(6'h2B, 0, 4, 16'h24), 4);
    add(32'h118, enc_r(2, 1, 6, 6'h22), 4);
    add(32'h11C, enc_r(1, 2, 7, 6'h24), 4);
    add(32'h120, enc_r(1, 2, 8, 6'h25), 4);
    add(32'h124, enc_r(1, 2, 9, 6'h2A), 4);
    add(32'h128, enc_i(6'h2B, 0, 6, 16'h28), 4);
    add(32'h12C, enc_i(6'h2B, 0, 7, 16'h2C), 4);
    add(32'h130, enc_i(6'h2B, 0, 8, 16'h30), 4);
    add(32'h134, enc_i(6'h2B, 0, 9, 16'h34), 4);
    add(32'h138, enc_i(6'h08, 0, 0, 16'd7), 4);
    add(32'h13C, enc_r(0, 0, 1, 6'h20), 4);
    add(32'h140, enc_i(6'h2B, 0, 1, 16'h38), 4);
    add(32'h144, enc_i(6'h08, 8, 11, 16'd4), 4);
    add(32'h148, enc_i(6'h2B, 0, 11, 16'h40), 4);
    add(32'h14C, 32'hFC00_0000, 0);
    exp_wr(32'h20, 32'd2);
    exp_wr(32'h24, 32'd1);
    exp_wr(32'h28, 32'hFFFF_FFF8);
    exp_wr(32'h2C, 32'd5);
    exp_wr(32'h30, 32'hFFFF_FFFD);
    exp_wr(32'h34, 32'd0);
    exp_wr(32'h38, 32'd0);
    exp_wr(32'h40, 32'd1);
    run_prog(0, 0, 1'b1);

    // Data wait states, address masking, branches and jump.
    add(32'h100, enc_i(6'h08, 0, 3, 16'd2), 4);
    add(32'h104, enc_i(6'h2B, 0, 3, 16'h8), 6);
    add(32'h108, enc_i(6'h23, 0, 5, 16'h8), 7);
    add(32'h10C, enc_i(6'h2B, 0, 5, 16'hF), 6);
    add(32'h110, enc_i(6'h04, 3, 5, 16'd2), 3);
    add(32'h11C, enc_i(6'h04, 3, 0, 16'd5), 3);
    add(32'h120, {6'h02, 26'h50}, 2);
    add(32'h140, 32'hFC00_0000, 0);
    exp_wr(32'h8, 32'd2);
    exp_wr(32'hC, 32'd2);
    run_prog(0, 2, 1'b0);

    // Fetch wait states and a backward branch.
    add(32'h100, enc_i(6'h08, 0, 1, 16'hFFFF), 5);
    add(32'h104, enc_i(6'h2B, 0, 1, 16'h10), 6);
    add(32'h108, {6'h02, 26'h44}, 3);
    add(32'h110, enc_i(6'h04, 0, 0, 16'd1), 4);
    add(32'h118, enc_i(6'h04, 1, 1, 16'hFFFC), 4);
    add(32'h10C, 32'hFC00_0000, 0);
    exp_wr(32'h10, 32'hFFFF_FFFF);
    run_prog(1, 1, 1'b0);

    // Reset asserted while a load waits in MEM aborts it and refetches from the reset vector.
    rst_n = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    mem[ResetPc[9:2]] = enc_i(6'h23, 0, 5, 16'h8);
    mem[2] = 32'hDEAD_BEEF;
    wait_ins = 0; wait_dat = 10; wcnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    reached = 1'b0;
    for (int t = 0; t < 20 && !reached; t++) begin
      @(negedge clk);
      drive_mem();
      #1;
      if (mem_req && mem_addr == 32'h8 && wcnt >= 3) reached = 1'b1;
    end
    if (!reached) fail("abort setup", "load never reached its memory wait");
    rst_n = 1'b0;
    #1;
    check("abort req", {31'd0, mem_req}, 32'd0);
    check("abort addr", mem_addr, 32'd0);
    check("abort retire", {31'd0, retire}, 32'd0);
    check("abort pc_o", pc, ResetPc);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("refetch req", {31'd0, mem_req}, 32'd1);
    check("refetch addr", mem_addr, ResetPc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_cpu.md
# multi_cycle_cpu

Multi-cycle MIPS-subset processor core, successor to the single-cycle CPU. Executes each instruction over 2–5 states, sharing one ALU and one external memory port for instruction fetch and data access, with a req/ready handshake. Contains its own 32×32 register file. Adds load/store, jump, wait-state tolerance, illegal-opcode handling, a configurable reset vector and retire/halt status for the bench.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- HALT_ON_ILLEGAL, 1, 1: illegal instruction halts the core; 0: it retires as a NOP.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write (sw), 0 = read.
- mem_addr_o  out  32  byte address, bits [1:0] always 0.
- mem_wdata_o  out  32  store data.
- mem_rdata_i  in  32  read data, valid when mem_ready_i=1 on a read.
- mem_ready_i  in  1  completes the pending request in the cycle it is high.
- pc_o  out  32  address of the instruction in flight.
- retire_o  out  1  one-cycle pulse, last cycle of each instruction.
- halt_o  out  1  core halted.
- illegal_o  out  1  halt caused by illegal instruction.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: req=1, we=0, addr=pc. Hold until mem_ready_i=1; then IR<=mem_rdata_i, pc_o<=pc, pc<=pc+4 → DECODE.
- DECODE: A<=R[rs], B<=R[rt], target<=pc+4+(sext(imm16)<<2). j: pc<={pc+4[31:28],imm26,2'b00}, retire → FETCH. Illegal: HALT_ON_ILLEGAL=1 → HALT with illegal_o=1; else retire → FETCH.
- EXEC: R-type/addi → WB; lw/sw: addr<=A+sext(imm16) → MEM; beq: if A==B pc<=target; retire → FETCH.
- MEM: req=1, addr={addr[31:2],2'b00}, we=1 for sw with wdata=B. Hold until ready. sw: retire → FETCH; lw: MDR<=mem_rdata_i → WB.
- WB: R-type writes rd, addi/lw write rt; retire → FETCH. Writes to $0 discarded; R[0] reads 0.
- Opcodes: 0x00 R-type, 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j. R-type funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Any other opcode/funct is illegal.
- Arithmetic modulo 2^32, no overflow trap. slt result is 32'd1 or 32'd0.
- HALT: req=0, halt_o=1, no register/pc change; left only by reset.

## Timing
- Reset (rst_i=0) immediately: state=FETCH, pc=RESET_PC, pc_o=RESET_PC, register file all 0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, retire_o=0, halt_o=0, illegal_o=0.
- First cycle after reset release: mem_req_o=1, mem_addr_o=RESET_PC.
- mem_addr_o/mem_we_o/mem_wdata_o stable while mem_req_o=1 and mem_ready_i=0. Ready with req=0 is ignored.
- Instruction cycles with zero wait states: j 2, beq 3, sw 4, R-type/addi 4, lw 5. Each ready-low cycle in FETCH/MEM adds one cycle.
- Register write takes effect at the WB edge; the next instruction's DECODE sees it.
- Reset asserted mid-transfer aborts it. No write from the aborted instruction completes, except a memory write already accepted.

## Test plan
- Reset with RESET_PC=32'h100, ready tied 1 → first req at 0x100; pc_o=0x100; all outputs 0 during reset.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 → R3=2, R4=1; retire pulses at cycles 4, 8, 12, 16.
- sw $3,8($0) then lw $5,8($0), with ready low for 2 cycles per access → write addr 0x8 with data 2; R5=2; lw takes 7 cycles.
- beq taken (+2) at 0x10 → next fetch 0x1C; not-taken → 0x14. j 0x40 → fetch 0x100.
- Opcode 0x3F, HALT_ON_ILLEGAL=1 → halt_o=illegal_o=1, no further req. With HALT_ON_ILLEGAL=0 → retire after 2 cycles, fetch pc+4.
- addi $0,$0,7 then add $1,$0,$0 → R1=0. rst_i pulsed low during a lw MEM wait → req drops immediately, refetch at RESET_PC.
